// File: rtl/conv_layer_scheduler_if.sv
// Handshake/bus bundle between the layer scheduler and its neighbours
// (layer buffers, featuremap datapath, layer controller).
interface conv_layer_scheduler_if #(
  parameter int ADDR_W  = 14,
  parameter int PASS_W  = 5,
  parameter int OADDR_W = 19
);
  logic               start;
  logic               stall;
  logic               busy;
  logic               done;
  logic               error;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               dp_valid_in;
  logic [PASS_W-1:0]  pass_idx;
  logic               dp_valid_out;
  logic               wr_en;
  logic [OADDR_W-1:0] wr_addr;

  // scheduler side
  modport slave (
    input  start, stall, dp_valid_out,
    output busy, done, error, rd_en, rd_addr, dp_valid_in, pass_idx, wr_en, wr_addr
  );

  // controller / environment side
  modport master (
    output start, stall, dp_valid_out,
    input  busy, done, error, rd_en, rd_addr, dp_valid_in, pass_idx, wr_en, wr_addr
  );
endinterface

// File: rtl/conv_layer_scheduler.sv
// Convolution layer scheduler: runs NUM_PASSES weight-bank passes, each
// streaming IMG_SIZE*IMG_SIZE input pixels to the datapath, counts the
// datapath results and generates output buffer write addresses.
module conv_layer_scheduler #(
  parameter int IMG_SIZE     = 104,
  parameter int NUM_PASSES   = 32,
  parameter int OUT_PER_PASS = 10816,
  parameter int ADDR_W       = 14,
  parameter int PASS_W       = 5,
  parameter int OADDR_W      = 19
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  conv_layer_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(OUT_PER_PASS + 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [PASS_W-1:0] LAST_P = PASS_W'(NUM_PASSES - 1);
  localparam logic [CNT_W-1:0]  OUT_C  = CNT_W'(OUT_PER_PASS);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_NEXT, S_DONE} state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_ptr;      // next input address to issue
  logic                r_dp_vld;
  logic [PASS_W-1:0]   r_pass;
  logic [CNT_W-1:0]    r_cnt;      // results accepted in this pass
  logic                r_wr_en;
  logic [OADDR_W-1:0]  r_wr_addr;
  logic [OADDR_W-1:0]  r_wacc;     // next output address, accumulates over passes

  logic w_cnt_open;
  logic w_accept;
  logic w_unexp;

  // a result is only expected while streaming/draining and the pass is not full
  assign w_cnt_open = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && (r_cnt != OUT_C);
  assign w_accept   = bus.dp_valid_out && w_cnt_open;
  assign w_unexp    = bus.dp_valid_out && !w_cnt_open;

  // FSM, read sequencing, result counting; every output is registered here
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_ptr     <= '0;
      r_dp_vld  <= 1'b0;
      r_pass    <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wacc    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rd_en  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_dp_vld <= r_rd_en;             // buffer read latency of one cycle

      if (w_accept) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_wacc;
        r_wacc    <= r_wacc + OADDR_W'(1);
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (w_unexp) r_error <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_STREAM;
            r_busy    <= 1'b1;
            r_pass    <= '0;
            r_cnt     <= '0;
            r_wacc    <= '0;
            r_error   <= w_unexp;      // start clears, a same-cycle stray result still counts
            // first read goes out together with busy unless stalled
            r_rd_en   <= !bus.stall;
            r_rd_addr <= '0;
            r_ptr     <= bus.stall ? '0 : ADDR_W'(1);
          end
        end
        S_STREAM: begin
          if (r_rd_en && (r_rd_addr == LAST_A)) begin
            r_state <= S_DRAIN;
          end else if (!bus.stall) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_ptr;
            r_ptr     <= r_ptr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == OUT_C) begin
            if (r_pass == LAST_P) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          r_state   <= S_STREAM;
          r_pass    <= r_pass + PASS_W'(1);
          r_cnt     <= '0;
          // restart the read stream so the new pass has no bubble
          r_rd_en   <= !bus.stall;
          r_rd_addr <= '0;
          r_ptr     <= bus.stall ? '0 : ADDR_W'(1);
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_pass    <= '0;
          r_cnt     <= '0;
          r_wacc    <= '0;
          r_rd_addr <= '0;
          r_ptr     <= '0;
          r_wr_addr <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;
  assign bus.rd_en       = r_rd_en;
  assign bus.rd_addr     = r_rd_addr;
  assign bus.dp_valid_in = r_dp_vld;
  assign bus.pass_idx    = r_pass;
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;

endmodule

// File: doc/conv_layer_scheduler.md
# conv_layer_scheduler

Sequences one convolution layer through a shared featuremap datapath. The layer is computed in NUM_PASSES passes; each pass selects one weight bank and streams IMG_SIZE×IMG_SIZE input pixels from the layer input buffer into the datapath. The block counts datapath results and generates write addresses into the layer output buffer. It sits between the layer input/output buffers and the bank of featuremap units.

## Interface
- IMG_SIZE, 104, input image width and height in pixels
- NUM_PASSES, 32, number of weight-bank passes per layer
- OUT_PER_PASS, 10816, results expected from the datapath per pass (IMG_SIZE*IMG_SIZE)
- ADDR_W, 14, input buffer address width; holds IMG_SIZE*IMG_SIZE-1
- PASS_W, 5, pass index width; holds NUM_PASSES-1
- OADDR_W, 19, output buffer address width; holds NUM_PASSES*OUT_PER_PASS-1

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a layer; ignored unless IDLE
- stall  in  1  back-pressure; while high no new buffer read is issued
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last result of the last pass is written
- error  out  1  sticky; set on an unexpected dp_valid_out, cleared by accepted start
- rd_en  out  1  input buffer read strobe
- rd_addr  out  ADDR_W  input buffer read address
- dp_valid_in  out  1  valid to datapath; rd_en delayed one cycle (buffer read latency 1)
- pass_idx  out  PASS_W  weight-bank select; stable for a whole pass
- dp_valid_out  in  1  datapath result valid
- wr_en  out  1  output buffer write strobe; equals dp_valid_out when expected
- wr_addr  out  OADDR_W  pass_idx*OUT_PER_PASS + result count

## Operation
- States: IDLE, STREAM, DRAIN, NEXT, DONE.
- IDLE: all counters hold 0. On start go to STREAM; pass_idx=0; clear error.
- STREAM: each cycle with stall low, assert rd_en at rd_addr and then increment rd_addr. When rd_en fires at address IMG_SIZE*IMG_SIZE-1, go to DRAIN. With stall high, rd_en is 0 and rd_addr holds.
- DRAIN: no reads. Wait until the result count reaches OUT_PER_PASS. Then go to NEXT if pass_idx<NUM_PASSES-1, otherwise go to DONE.
- NEXT: one cycle. Increment pass_idx; reset rd_addr and the result count to 0; go to STREAM.
- DONE: one cycle. Assert done; go to IDLE.
- Result counting runs in STREAM and DRAIN. Each dp_valid_out while count<OUT_PER_PASS asserts wr_en with the current wr_addr and then increments count.
- Unexpected result: dp_valid_out in IDLE, NEXT or DONE, or with count==OUT_PER_PASS. Effect: set error; wr_en stays 0; count does not change.
- Arithmetic: all counters are unsigned. wr_addr is registered, so no multiplier is needed: it is 0 on start and accumulates over passes.

## Timing
- Reset values: busy=0, done=0, error=0, rd_en=0, rd_addr=0, dp_valid_in=0, pass_idx=0, wr_en=0, wr_addr=0, state=IDLE.
- start sampled high in IDLE: busy=1 and first rd_en in the next cycle. dp_valid_in follows one cycle after that.
- rd_en, rd_addr, wr_en and wr_addr are registered outputs. wr_en goes high the cycle after the dp_valid_out that caused it.
- Minimum pass length with no stall: IMG_SIZE² read cycles, plus datapath latency, plus 1 NEXT cycle.
- done rises one cycle after the final wr_en; busy falls together with done.
- start while busy is ignored, with no effect on state or error.
- stall and dp_valid_out in the same cycle: the read is held and the result is still counted.
- Rst asserted mid-operation: everything returns immediately to reset values. Any in-flight datapath results arriving after release in IDLE set error.

## Test plan
- Reset, then IMG_SIZE=4, NUM_PASSES=2, OUT_PER_PASS=16, model datapath latency 5, start, no stall. Required: rd_addr 0..15 twice; pass_idx 0 then 1; wr_addr 0..31 in order; done pulses once; 32 wr_en total; error=0.
- Same setup with stall high on every third cycle. Required: rd_addr never skips or repeats; wr_addr sequence is identical to the first test.
- Inject one extra dp_valid_out after the 16th result of pass 0. Required: error=1; no write; wr_addr continues at 16 in pass 1; error clears on the next start.
- Pulse start while busy in mid-pass 0. Required: no change in pass_idx or rd_addr; a single done at the end.
- Assert Rst during pass 1 STREAM. Required: all outputs at reset values in the same cycle; a new start runs a full clean layer.
- NUM_PASSES=1, IMG_SIZE=3, OUT_PER_PASS=9. Required: no NEXT state visited; done one cycle after the 9th wr_en.
